// File: rtl/tdm_pkg.sv
// tdm_pkg: constants and types shared by the TDM link receive/transmit blocks.
//   NCH    - channels per frame
//   CH_W   - width of a slot index
//   state_e - framing state of the receiver
package tdm_pkg;
  localparam int NCH  = 4;
  localparam int CH_W = 2;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  // Slot index following c; wraps NCH-1 -> 0 because NCH is a power of two.
  function automatic logic [CH_W-1:0] next_slot(input logic [CH_W-1:0] c);
    return c + 1'b1;
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index of the next expected sample.
//   clk, rst      - clock, synchronous active-high reset (clears to slot 0)
//   adv_i         - step to the next slot (wraps 3 -> 0)
//   load1_i       - a channel-0 sample was taken; next slot is 1
//   clr_i         - return to slot 0
//   ch_o          - current slot index
//   last_slot_o   - ch_o is the final slot of a frame
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            adv_i,
  input  logic            load1_i,
  input  logic            clr_i,
  output logic [CH_W-1:0] ch_o,
  output logic            last_slot_o
);
  logic [CH_W-1:0] ch_q, ch_d;

  // clear beats load beats advance
  always_comb begin
    ch_d = ch_q;
    if (clr_i)        ch_d = '0;
    else if (load1_i) ch_d = CH_W'(1);
    else if (adv_i)   ch_d = next_slot(ch_q);
  end

  always_ff @(posedge clk) begin
    if (rst) ch_q <= '0;
    else     ch_q <= ch_d;
  end

  assign ch_o        = ch_q;
  assign last_slot_o = (ch_q == CH_W'(NCH-1));
endmodule

// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: receive side of the 4:1 TDM link.
//   clk, rst     - clock, synchronous active-high reset
//   din          - multiplexed sample (WIDTH bits)
//   din_valid    - din carries a sample this cycle
//   frame_sync   - with din_valid, marks din as channel 0
//   y            - last complete frame, channel k at y[WIDTH*k +: WIDTH]
//   frame_valid  - one-cycle pulse when y takes a new frame
//   locked       - receiver is frame-locked
//   sync_err     - one-cycle pulse on a framing violation
//   ch           - slot expected for the next sample
module tdm_demux_1_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [NCH*WIDTH-1:0] y,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 sync_err,
  output logic [CH_W-1:0]      ch
);
  state_e                          state_q, state_d;
  // Channels 0..NCH-2 wait here; the last channel goes straight to y.
  logic [NCH-2:0][WIDTH-1:0]       shadow_q;
  logic [NCH*WIDTH-1:0]            y_q;
  logic                            fv_q, err_q;
  logic                            adv, load1, clr, wr_sh, emit, err, last_slot;
  logic [CH_W-1:0]                 ch_cur;

  tdm_slot_counter u_slot (
    .clk         (clk),
    .rst         (rst),
    .adv_i       (adv),
    .load1_i     (load1),
    .clr_i       (clr),
    .ch_o        (ch_cur),
    .last_slot_o (last_slot)
  );

  // Beat decode. Idle cycles leave every control low.
  always_comb begin
    adv = 1'b0; load1 = 1'b0; clr = 1'b0; wr_sh = 1'b0; emit = 1'b0; err = 1'b0;
    state_d = state_q;
    if (din_valid) begin
      unique case (state_q)
        HUNT: if (frame_sync) begin
          load1   = 1'b1;
          state_d = LOCKED;
        end
        LOCKED: begin
          if (frame_sync) begin
            // early sync restarts the frame on this beat
            load1 = 1'b1;
            err   = (ch_cur != '0);
          end else if (ch_cur == '0) begin
            // missing sync: drop the beat and lose lock
            err     = 1'b1;
            clr     = 1'b1;
            state_d = HUNT;
          end else begin
            adv = 1'b1;
            if (last_slot) emit  = 1'b1;
            else           wr_sh = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= emit;
      err_q   <= err;
      if (load1) shadow_q[0]      <= din;
      if (wr_sh) shadow_q[ch_cur] <= din;
      // whole frame moves to y in one edge, so y is never partial
      if (emit)  y_q <= {din, shadow_q};
    end
  end

  assign y           = y_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == LOCKED);
  assign ch          = ch_cur;
endmodule
